// File: rtl/loss_scheduler.sv
// Sequences one loss-gradient batch: issues H/Y reads, feeds the gradient lane and writes results back.
// Reads 1 cycle to data and lane inputs; writes are combinational on grad_valid_in; stall_in only pauses reads.
module loss_scheduler #(
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_in,
    input  logic [ADDR_W-1:0]        batch_size_in,
    input  logic signed [15:0]       inv_batch_size_times_two_in,
    input  logic                     stall_in,
    output logic                     rd_en_out,
    output logic [ADDR_W-1:0]        rd_addr_out,
    input  logic signed [15:0]       H_rd_data_in,
    input  logic signed [15:0]       Y_rd_data_in,
    output logic signed [15:0]       H_out,
    output logic signed [15:0]       Y_out,
    output logic                     lane_valid_out,
    output logic signed [15:0]       inv_batch_size_times_two_out,
    input  logic signed [15:0]       gradient_in,
    input  logic                     grad_valid_in,
    output logic                     wr_en_out,
    output logic [ADDR_W-1:0]        wr_addr_out,
    output logic signed [15:0]       wr_data_out,
    output logic                     busy_out,
    output logic                     done_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  n_q;
    logic [ADDR_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0]  wr_cnt;
    logic signed [15:0] inv_q;
    logic               lane_vld_q;
    logic               active;

    assign active      = (state == ISSUE) || (state == DRAIN);
    assign rd_en_out   = (state == ISSUE) && !stall_in;
    assign rd_addr_out = rd_cnt;

    assign H_out                        = H_rd_data_in;
    assign Y_out                        = Y_rd_data_in;
    assign lane_valid_out               = lane_vld_q;
    assign inv_batch_size_times_two_out = inv_q;

    // Lane results outside a batch (e.g. in flight across a reset) are dropped here.
    assign wr_en_out   = grad_valid_in && active && (wr_cnt != n_q);
    assign wr_addr_out = wr_cnt;
    assign wr_data_out = gradient_in;

    assign busy_out = active;
    assign done_out = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_q        <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            inv_q      <= '0;
            lane_vld_q <= 1'b0;
        end else begin
            lane_vld_q <= rd_en_out;
            if (wr_en_out) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start_in) begin
                        if (batch_size_in != '0) begin
                            n_q    <= batch_size_in;
                            inv_q  <= inv_batch_size_times_two_in;
                            rd_cnt <= '0;
                            wr_cnt <= '0;
                            state  <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_en_out) begin
                        rd_cnt <= rd_cnt + ADDR_W'(1);
                        if (rd_cnt == n_q - ADDR_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the final write so done follows it by exactly one cycle.
                    if ((wr_en_out && (wr_cnt == n_q - ADDR_W'(1))) || (wr_cnt == n_q)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loss_scheduler.sv
// Bench for loss_scheduler: memory and lane responders plus directed and randomized batch scenarios.
module tb_loss_scheduler;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_in = 1'b0;
    logic [7:0]         batch_size_in = '0;
    logic signed [15:0] inv_in = '0;
    logic               stall_in = 1'b0;
    logic               rd_en;
    logic [7:0]         rd_addr;
    logic signed [15:0] H_rd = '0;
    logic signed [15:0] Y_rd = '0;
    logic signed [15:0] H_out;
    logic signed [15:0] Y_out;
    logic               lane_valid;
    logic signed [15:0] inv_out;
    logic signed [15:0] gradient = '0;
    logic               grad_valid = 1'b0;
    logic               wr_en;
    logic [7:0]         wr_addr;
    logic signed [15:0] wr_data;
    logic               busy;
    logic               done;

    loss_scheduler #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .batch_size_in(batch_size_in),
        .inv_batch_size_times_two_in(inv_in), .stall_in(stall_in),
        .rd_en_out(rd_en), .rd_addr_out(rd_addr),
        .H_rd_data_in(H_rd), .Y_rd_data_in(Y_rd),
        .H_out(H_out), .Y_out(Y_out), .lane_valid_out(lane_valid),
        .inv_batch_size_times_two_out(inv_out),
        .gradient_in(gradient), .grad_valid_in(grad_valid),
        .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
        .busy_out(busy), .done_out(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic signed [15:0] H_mem [256];
    logic signed [15:0] Y_mem [256];
    logic signed [15:0] got   [256];
    int                 wcount[256];
    int cyc = 0, n_wr = 0, n_rd = 0, n_done = 0, n_busy = 0, max_rd = -1, last_wr = -1, done_at = -1;

    // Lane: gradient = (H - Y) * 2/N, 8 fractional bits in 2/N.
    function automatic logic signed [15:0] lane_fn(input logic signed [15:0] h, input logic signed [15:0] y,
                                                   input logic signed [15:0] inv);
        int d, p;
        d = int'(h) - int'(y);
        p = d * int'(inv);
        return 16'(p >>> 8);
    endfunction

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            H_rd <= H_mem[rd_addr];
            Y_rd <= Y_mem[rd_addr];
        end
    end

    always @(posedge clk) begin
        grad_valid <= (lane_valid === 1'b1);
        gradient   <= lane_fn(H_out, Y_out, inv_out);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wr_en === 1'b1) begin
            wcount[wr_addr]++;
            got[wr_addr] = wr_data;
            n_wr++;
            last_wr = cyc;
        end
        if (rd_en === 1'b1) begin
            n_rd++;
            if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
        end
        if (done === 1'b1) begin
            n_done++;
            done_at = cyc;
        end
        if (busy === 1'b1) n_busy++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 256; i++) begin
            wcount[i] = 0;
            got[i]    = 'x;
        end
        n_wr = 0; n_rd = 0; n_done = 0; n_busy = 0; max_rd = -1; last_wr = -1; done_at = -1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) begin
            H_mem[i] = 16'($urandom);
            Y_mem[i] = 16'($urandom);
        end
    endtask

    // Drives one batch to completion; random stalls with the given percentage.
    task automatic run_batch(input int n, input logic signed [15:0] inv, input int stall_pct,
                             output int start_cyc, output bit timed_out);
        int k;
        batch_size_in = 8'(n);
        inv_in        = inv;
        start_in      = 1'b1;
        start_cyc     = cyc;
        tick();
        start_in  = 1'b0;
        k         = 0;
        timed_out = 1'b1;
        while (k < 4 * n + 40) begin
            stall_in = ($urandom_range(99) < stall_pct);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick();
            k++;
        end
        stall_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        vectors++; if (lane_valid !== 1'b0) begin miscompares++; $display("FAIL reset_lane_valid: got %b want 0", lane_valid); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        vectors++; if (inv_out !== 16'sd0) begin miscompares++; $display("FAIL reset_inv: got %h want 0000", inv_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] ea;
        fill_mem();
        clear_stats();
        batch_size_in = 8'd4;
        inv_in        = 16'sh0080;
        start_in      = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            vectors++; if (rd_en !== (c >= 1 && c <= 4)) begin miscompares++; $display("FAIL basic_rd_en c%0d: got %b want %b", c, rd_en, (c >= 1 && c <= 4)); end
            if (c >= 1 && c <= 4) begin
                ea = 8'(c - 1);
                vectors++; if (rd_addr !== ea) begin miscompares++; $display("FAIL basic_rd_addr c%0d: got %0d want %0d", c, rd_addr, ea); end
            end
            vectors++; if (lane_valid !== (c >= 2 && c <= 5)) begin miscompares++; $display("FAIL basic_lane_valid c%0d: got %b", c, lane_valid); end
            if (c >= 2 && c <= 5) begin
                vectors++; if (H_out !== H_mem[c-2] || Y_out !== Y_mem[c-2]) begin miscompares++; $display("FAIL basic_lane_data c%0d: got %h/%h want %h/%h", c, H_out, Y_out, H_mem[c-2], Y_mem[c-2]); end
            end
            vectors++; if (wr_en !== (c >= 3 && c <= 6)) begin miscompares++; $display("FAIL basic_wr_en c%0d: got %b", c, wr_en); end
            if (c >= 3 && c <= 6) begin
                ea = 8'(c - 3);
                vectors++; if (wr_addr !== ea || wr_data !== lane_fn(H_mem[c-3], Y_mem[c-3], 16'sh0080)) begin
                    miscompares++; $display("FAIL basic_write c%0d: got @%0d=%h want @%0d=%h", c, wr_addr, wr_data, ea, lane_fn(H_mem[c-3], Y_mem[c-3], 16'sh0080));
                end
            end
            vectors++; if (done !== (c == 7)) begin miscompares++; $display("FAIL basic_done c%0d: got %b", c, done); end
            vectors++; if (busy !== (c >= 1 && c <= 6)) begin miscompares++; $display("FAIL basic_busy c%0d: got %b", c, busy); end
            vectors++; if (inv_out !== 16'sh0080) begin miscompares++; $display("FAIL basic_inv c%0d: got %h want 0080", c, inv_out); end
            tick();
        end
    endtask

    task automatic test_stall();
        int s;
        fill_mem();
        clear_stats();
        batch_size_in = 8'd4;
        inv_in        = 16'sh0040;
        start_in      = 1'b1;
        s = cyc;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            stall_in = (c == 2 || c == 3);
            #1;
            vectors++; if (rd_en !== (c == 1 || (c >= 4 && c <= 6))) begin miscompares++; $display("FAIL stall_rd_en c%0d: got %b", c, rd_en); end
            tick();
        end
        stall_in = 1'b0;
        for (int a = 0; a < 4; a++) begin
            vectors++; if (wcount[a] !== 1 || got[a] !== lane_fn(H_mem[a], Y_mem[a], 16'sh0040)) begin
                miscompares++; $display("FAIL stall_write a%0d: got count %0d data %h want 1 %h", a, wcount[a], got[a], lane_fn(H_mem[a], Y_mem[a], 16'sh0040));
            end
        end
        vectors++; if (n_done !== 1 || done_at !== last_wr + 1 || last_wr - s !== 8) begin
            miscompares++; $display("FAIL stall_done: got done %0d at %0d last write %0d want 1 at last write+1 (write at cycle 8)", n_done, done_at - s, last_wr - s);
        end
    endtask

    task automatic test_zero();
        clear_stats();
        batch_size_in = 8'd0;
        inv_in        = 16'sh7fff;
        start_in      = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (done !== (c == 1) || busy !== 1'b0) begin miscompares++; $display("FAIL zero_done_busy c%0d: got %b%b want %b0", c, done, busy, (c == 1)); end
            tick();
        end
        vectors++; if (n_rd !== 0 || n_wr !== 0) begin miscompares++; $display("FAIL zero_traffic: got %0d reads %0d writes want 0 0", n_rd, n_wr); end
    endtask

    task automatic test_ignore_start();
        int s;
        fill_mem();
        clear_stats();
        batch_size_in = 8'd4;
        inv_in        = 16'sh0080;
        start_in      = 1'b1;
        s = cyc;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            start_in = (c == 2);
            if (c == 2) begin
                batch_size_in = 8'd9;
                inv_in        = 16'sh1234;
            end
            tick();
            start_in = 1'b0;
            if (cyc - s <= 6) begin
                vectors++; if (inv_out !== 16'sh0080) begin miscompares++; $display("FAIL ignore_inv c%0d: got %h want 0080", cyc - s, inv_out); end
            end
        end
        vectors++; if (n_rd !== 4 || n_wr !== 4) begin miscompares++; $display("FAIL ignore_count: got %0d reads %0d writes want 4 4", n_rd, n_wr); end
        vectors++; if (n_done !== 1 || done_at - s !== 7 || n_busy !== 6) begin
            miscompares++; $display("FAIL ignore_done: got %0d dones at %0d busy %0d want 1 at 7 busy 6", n_done, done_at - s, n_busy);
        end
    endtask

    task automatic test_midreset();
        int s;
        bit to;
        fill_mem();
        clear_stats();
        batch_size_in = 8'd8;
        inv_in        = 16'sh0100;
        start_in      = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (rd_en !== 1'b0 || lane_valid !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++; $display("FAIL midrst_ctrl: got rd %b lane %b wr %b want 000", rd_en, lane_valid, wr_en);
        end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || inv_out !== 16'sd0) begin
            miscompares++; $display("FAIL midrst_status: got busy %b done %b inv %h want 0 0 0000", busy, done, inv_out);
        end
        repeat (15) tick();
        vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
        clear_stats();
        run_batch(3, 16'sh0080, 0, s, to);
        vectors++; if (to || n_done !== 1 || n_wr !== 3) begin miscompares++; $display("FAIL midrst_recover: got timeout %0d done %0d writes %0d want 0 1 3", to, n_done, n_wr); end
        for (int a = 0; a < 3; a++) begin
            vectors++; if (wcount[a] !== 1 || got[a] !== lane_fn(H_mem[a], Y_mem[a], 16'sh0080)) begin
                miscompares++; $display("FAIL midrst_write a%0d: got count %0d data %h", a, wcount[a], got[a]);
            end
        end
    endtask

    task automatic test_reset_start();
        clear_stats();
        batch_size_in = 8'd5;
        inv_in        = 16'sh0066;
        rst           = 1'b1;
        start_in      = 1'b1;
        tick();
        rst      = 1'b0;
        start_in = 1'b0;
        repeat (10) tick();
        vectors++; if (n_busy !== 0 || n_rd !== 0 || n_done !== 0) begin
            miscompares++; $display("FAIL rst_start: got busy %0d reads %0d dones %0d want 0 0 0", n_busy, n_rd, n_done);
        end
    endtask

    task automatic test_random();
        int n, s;
        bit to;
        logic signed [15:0] inv;
        for (int b = 0; b < 8; b++) begin
            fill_mem();
            clear_stats();
            n   = (b == 0) ? 255 : (b == 1) ? 1 : int'($urandom_range(255, 1));
            inv = 16'($urandom);
            run_batch(n, inv, 30, s, to);
            vectors++; if (to) begin miscompares++; $display("FAIL rand_timeout b%0d: no done within budget for N=%0d", b, n); end
            vectors++; if (n_done !== 1 || n_rd !== n || max_rd !== n - 1) begin
                miscompares++; $display("FAIL rand_counts b%0d: got %0d dones %0d reads max addr %0d want 1 %0d %0d", b, n_done, n_rd, max_rd, n, n - 1);
            end
            for (int a = 0; a < 256; a++) begin
                if (a < n) begin
                    vectors++; if (wcount[a] !== 1 || got[a] !== lane_fn(H_mem[a], Y_mem[a], inv)) begin
                        miscompares++; $display("FAIL rand_write b%0d a%0d: got count %0d data %h want 1 %h", b, a, wcount[a], got[a], lane_fn(H_mem[a], Y_mem[a], inv));
                    end
                end else if (wcount[a] != 0) begin
                    vectors++; miscompares++; $display("FAIL rand_extra_write b%0d a%0d: got count %0d want 0", b, a, wcount[a]);
                end
            end
        end
    endtask

    initial begin
        clear_stats();
        fill_mem();
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_ignore_start();
        test_midreset();
        test_reset_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/loss_scheduler.md
LOSS_SCHEDULER -- requirements
Module: loss_scheduler

Interface
REQ-001 Parameter: ADDR_W, default 8, width of batch element addresses (maximum batch size 2^ADDR_W-1).
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_in  input  1  one-cycle request to process one batch.
REQ-005 batch_size_in  input  ADDR_W  N, element count; sampled with start_in.
REQ-006 inv_batch_size_times_two_in  input  16 signed  2/N in fixed-point; sampled with start_in.
REQ-007 stall_in  input  1  when high, no new element reads are issued.
REQ-008 rd_en_out / rd_addr_out  output  1 / ADDR_W  H and Y buffer read request; data returns exactly 1 cycle later.
REQ-009 H_rd_data_in / Y_rd_data_in  input  16 signed each  read data.
REQ-010 H_out / Y_out / lane_valid_out / inv_batch_size_times_two_out  output  16/16/1/16  drive to the gradient lane (1-cycle latency, no backpressure).
REQ-011 gradient_in / grad_valid_in  input  16 signed / 1  lane result.
REQ-012 wr_en_out / wr_addr_out / wr_data_out  output  1 / ADDR_W / 16  gradient buffer write port, always accepted.
REQ-013 busy_out / done_out  output  1 / 1  batch in progress / one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: start_in=1 with N>0 -> latch N and 2/N, clear counters, go to ISSUE next cycle; start_in=1 with N=0 -> go to DONE with no reads or writes.
REQ-016 start_in outside IDLE SHALL be ignored; latched N and 2/N stay stable until the next accepted start.
REQ-017 ISSUE: each cycle with stall_in=0 -> rd_en_out=1, rd_addr_out=issue counter, counter +1; stall_in=1 -> rd_en_out=0, counter holds.
REQ-018 After issuing element N-1 -> go to DRAIN; no read is issued beyond address N-1.
REQ-019 lane_valid_out SHALL equal rd_en_out delayed one cycle (registered); H_out/Y_out are passed through combinationally from the read-data inputs.
REQ-020 inv_batch_size_times_two_out SHALL be the latched 2/N value at all times.
REQ-021 On each grad_valid_in=1: wr_en_out=1 in the same cycle, wr_data_out=gradient_in, wr_addr_out=write counter, then counter +1 (combinational write path).
REQ-022 grad_valid_in SHALL be ignored in IDLE and DONE.
REQ-023 DRAIN: go to DONE in the cycle after the write counter reaches N.
REQ-024 DONE: done_out=1 for exactly one cycle, then go to IDLE.
REQ-025 busy_out=1 in ISSUE and DRAIN, 0 otherwise.
REQ-026 Counters SHALL be ADDR_W bits wide with no wrap within a batch, since N<=2^ADDR_W-1.
REQ-027 Data is never modified; all arithmetic is performed in the lane.

Reset
REQ-028 rst=1 -> state IDLE; counters, latched N and 2/N, rd_en_out, lane_valid_out, wr_en_out, busy_out and done_out all 0 on the next edge.
REQ-029 rst mid-batch aborts the batch: no done_out pulse; in-flight lane results after reset are ignored (state IDLE).
REQ-030 Simultaneous rst and start_in -> reset wins; the start is lost.

Verification
REQ-031 N=4, 2/N=0x0080, no stall, start at cycle 0 -> rd_en cycles 1-4 at addresses 0-3; lane_valid cycles 2-5; writes cycles 3-6 at addresses 0-3; done_out cycle 7; busy cycles 1-6.
REQ-032 N=4 with stall_in=1 in cycles 2-3 -> reads at cycles 1, 4, 5, 6; write addresses stay contiguous 0-3; done_out one cycle after the 4th write.
REQ-033 N=0 start -> no rd_en or wr_en; done_out one cycle after the DONE transition; busy_out stays 0.
REQ-034 Second start_in during busy with N=9 -> ignored; the first batch count and 2/N output are unchanged.
REQ-035 rst at cycle 3 of an N=8 batch -> all outputs 0 next cycle; no done_out; a new start after reset completes normally.
REQ-036 Lane model of H-Y times 2/N, random N in 1-255 -> every buffer address 0..N-1 is written exactly once with the correct value; exactly one done_out per batch.
